riscv_prog_seq: RTL and testbench

Program sequencer for the 16-bit `simple_riscv` core. It holds a host-loadable instruction memory and a program counter, and drives the core's `instruction` bus one instruction per cycle. Run, single-step and halt are controlled by host pulses. When the sequencer is not issuing, it feeds NOPs so the core's registers and memory strobes stay quiet. It sits between the host or testbench and the core's `instruction` input.

---
 rtl/riscv_seq_pkg.sv | 23 ++
 rtl/prog_imem.sv | 32 +++
 rtl/riscv_prog_seq.sv | 118 +++++++++++
 tb/tb_riscv_prog_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_seq_pkg.sv
// Shared constants and types for the simple_riscv program sequencer and its benches.
package riscv_seq_pkg;

    localparam int                 INSTR_W    = 16;
    localparam logic [INSTR_W-1:0] NOP_INSTR  = 16'h6000;
    localparam logic [3:0]         HALT_OPC   = 4'hF;
    localparam logic [INSTR_W-1:0] HALT_INSTR = {HALT_OPC, 12'h000};

    // Core opcodes, shared with the core bench.
    localparam logic [3:0] OPC_LOAD  = 4'h0;
    localparam logic [3:0] OPC_STORE = 4'h1;
    localparam logic [3:0] OPC_ADD   = 4'h2;
    localparam logic [3:0] OPC_SUB   = 4'h3;
    localparam logic [3:0] OPC_AND   = 4'h4;
    localparam logic [3:0] OPC_OR    = 4'h5;

    typedef enum logic [1:0] {IDLE, RUN, STEP, DONE} seq_state_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: 4] == HALT_OPC;
    endfunction

endpackage

// File: rtl/prog_imem.sv
// Instruction memory for the program sequencer: one synchronous write port,
// one asynchronous read port, every entry reset to HALT.
module prog_imem
    import riscv_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PC_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we_i,
    input  logic [PC_W-1:0]    waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [PC_W-1:0]    raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    // NOTE: this array is reset on purpose so an unloaded program halts at once;
    // a plain storage RAM would normally be left without a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= HALT_INSTR;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/riscv_prog_seq.sv
// Program sequencer feeding the simple_riscv instruction bus from a host-loaded memory.
// Define PROG_SEQ_BKPT_EN to compile in a single-address breakpoint (bkpt_en/bkpt_addr).
module riscv_prog_seq
    import riscv_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PC_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_valid,
    input  logic [PC_W-1:0]    load_addr,
    input  logic [INSTR_W-1:0] load_data,
    output logic               load_ready,
    input  logic               run_start,
    input  logic               step,
    input  logic               halt_req,
`ifdef PROG_SEQ_BKPT_EN
    input  logic               bkpt_en,
    input  logic [PC_W-1:0]    bkpt_addr,
`endif
    output logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               done,
    output logic [7:0]         retired
);

    seq_state_t         state_q, state_d, issue_state;
    logic [PC_W-1:0]    pc_q, pc_d, fetch_addr;
    logic [INSTR_W-1:0] instr_q, instr_d, fetch_word;
    logic [7:0]         retired_q, retired_d, retired_base;
    logic               issue, fetch_halt, bkpt_hit;

    prog_imem #(.DEPTH(DEPTH), .PC_W(PC_W)) u_imem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (load_valid && load_ready),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (fetch_addr),
        .rdata_o (fetch_word)
    );

`ifdef PROG_SEQ_BKPT_EN
    assign bkpt_hit = bkpt_en && (pc_q == bkpt_addr);
`else
    assign bkpt_hit = 1'b0;
`endif

    // A restart from DONE rewinds to address 0 and clears the count on the same edge.
    assign fetch_addr   = (state_q == DONE) ? '0 : pc_q;
    assign retired_base = (state_q == DONE) ? '0 : retired_q;
    assign fetch_halt   = is_halt(fetch_word);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        retired_d   = retired_q;
        instr_d     = NOP_INSTR;
        issue       = 1'b0;
        issue_state = RUN;

        case (state_q)
            IDLE: begin
                if (!halt_req && (run_start || step)) begin
                    issue       = 1'b1;
                    issue_state = run_start ? RUN : STEP;
                end
            end
            RUN: begin
                if (fetch_halt || !(halt_req || bkpt_hit)) issue = 1'b1;
                else                                       state_d = IDLE;
            end
            STEP:    state_d = IDLE;
            DONE:    issue = run_start;
            default: state_d = IDLE;
        endcase

        if (issue) begin
            if (fetch_halt) begin
                state_d   = DONE;
                pc_d      = fetch_addr;
                retired_d = retired_base;
            end else begin
                state_d   = issue_state;
                instr_d   = fetch_word;
                pc_d      = fetch_addr + PC_W'(1);
                retired_d = (fetch_word != NOP_INSTR && retired_base != 8'hFF)
                          ? retired_base + 8'd1 : retired_base;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            instr_q   <= NOP_INSTR;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign instruction = instr_q;
    assign pc          = pc_q;
    assign retired     = retired_q;
    assign busy        = (state_q == RUN) || (state_q == STEP);
    assign done        = (state_q == DONE);
    assign load_ready  = (state_q == IDLE) || (state_q == DONE);

endmodule

// File: tb/tb_riscv_prog_seq.sv
// Self-checking bench for riscv_prog_seq: directed scenarios plus randomized pulses
// checked against a behavioural model. Define PROG_SEQ_BKPT_EN to cover the breakpoint.
module tb_riscv_prog_seq;
    import riscv_seq_pkg::*;

    localparam logic [15:0] NOP = 16'h6000;
    localparam logic [15:0] HLT = 16'hF000;

    logic        clk, reset;
    logic        load_valid, load_ready, run_start, step, halt_req, busy, done;
    logic [3:0]  load_addr, pc;
    logic [15:0] load_data, instruction;
    logic [7:0]  retired;
`ifdef PROG_SEQ_BKPT_EN
    logic        bkpt_en;
    logic [3:0]  bkpt_addr;
`endif

    riscv_prog_seq #(.DEPTH(16), .PC_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .run_start   (run_start),
        .step        (step),
        .halt_req    (halt_req),
`ifdef PROG_SEQ_BKPT_EN
        .bkpt_en     (bkpt_en),
        .bkpt_addr   (bkpt_addr),
`endif
        .instruction (instruction),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .retired     (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Behavioural model: program memory, next address, retire count and run mode.
    logic [15:0] m_mem [16];
    logic [3:0]  m_pc;
    int          m_ret;
    logic [15:0] m_instr;
    bit          m_running, m_single, m_ended;
    logic [15:0] prog [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = HLT;
        m_pc = '0; m_ret = 0; m_instr = NOP;
        m_running = 1'b0; m_single = 1'b0; m_ended = 1'b0;
    endtask

    task automatic model_clock();
        bit          can_load, do_issue, bk;
        logic [15:0] w;
        can_load = !(m_running || m_single);
        do_issue = 1'b0;
        bk       = 1'b0;
`ifdef PROG_SEQ_BKPT_EN
        bk = bkpt_en && (m_pc == bkpt_addr);
`endif
        m_instr = NOP;
        if (m_ended) begin
            if (run_start) begin
                m_pc = '0; m_ret = 0; m_ended = 1'b0; m_running = 1'b1; do_issue = 1'b1;
            end
        end else if (m_single) begin
            m_single = 1'b0;
        end else if (m_running) begin
            w = m_mem[m_pc];
            if (w[15:12] == 4'hF || !(halt_req || bk)) do_issue = 1'b1;
            else m_running = 1'b0;
        end else if (!halt_req && (run_start || step)) begin
            do_issue = 1'b1;
            if (run_start) m_running = 1'b1;
            else           m_single  = 1'b1;
        end
        if (do_issue) begin
            w = m_mem[m_pc];
            if (w[15:12] == 4'hF) begin
                m_ended = 1'b1; m_running = 1'b0; m_single = 1'b0;
            end else begin
                m_instr = w;
                m_pc    = m_pc + 4'd1;
                if (w != NOP && m_ret < 255) m_ret++;
            end
        end
        if (load_valid && can_load) m_mem[load_addr] = load_data;
    endtask

    task automatic check_all(input string tag);
        check({tag, ":instr"},      32'(instruction), 32'(m_instr));
        check({tag, ":pc"},         32'(pc),          32'(m_pc));
        check({tag, ":retired"},    32'(retired),     32'(m_ret));
        check({tag, ":busy"},       32'(busy),        32'(m_running || m_single));
        check({tag, ":done"},       32'(done),        32'(m_ended));
        check({tag, ":load_ready"}, 32'(load_ready),  32'(!(m_running || m_single)));
    endtask

    // Drive at the falling edge, let the rising edge act, compare at the next falling edge.
    task automatic cycle(input string tag, input bit rs = 1'b0, input bit st = 1'b0,
                         input bit hr = 1'b0, input bit lv = 1'b0,
                         input logic [3:0] la = 4'h0, input logic [15:0] ld = 16'h0);
        run_start = rs; step = st; halt_req = hr;
        load_valid = lv; load_addr = la; load_data = ld;
        @(posedge clk);
        model_clock();
        @(negedge clk);
        run_start = 1'b0; step = 1'b0; halt_req = 1'b0; load_valid = 1'b0;
        check_all(tag);
    endtask

    task automatic hard_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        check({tag, ":async_instr"}, 32'(instruction), 32'(NOP));
        check({tag, ":async_pc"},    32'(pc),          32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        check_all(tag);
    endtask

    function automatic logic [15:0] rand_word();
        logic [3:0] ops [6];
        ops = '{OPC_LOAD, OPC_STORE, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR};
        return {ops[$urandom_range(0, 5)], 12'($urandom)};
    endfunction

    task automatic load_prog(input string tag);
        for (int i = 0; i < 16; i++) cycle(tag, 1'b0, 1'b0, 1'b0, 1'b1, 4'(i), prog[i]);
    endtask

    initial begin
        reset = 1'b1; run_start = 1'b0; step = 1'b0; halt_req = 1'b0;
        load_valid = 1'b0; load_addr = '0; load_data = '0;
`ifdef PROG_SEQ_BKPT_EN
        bkpt_en = 1'b0; bkpt_addr = '0;
`endif
        model_reset();
        @(negedge clk);
        check("reset:instr",      32'(instruction), 32'h6000);
        check("reset:pc",         32'(pc),          32'h0);
        check("reset:busy",       32'(busy),        32'h0);
        check("reset:done",       32'(done),        32'h0);
        check("reset:retired",    32'(retired),     32'h0);
        check("reset:load_ready", 32'(load_ready),  32'h1);
        reset = 1'b0;
        check_all("reset_release");

        // Three-word program ending in HALT.
        prog[0] = 16'h2312; prog[1] = 16'h3312; prog[2] = HLT;
        for (int i = 0; i < 3; i++) cycle("t1_load", 1'b0, 1'b0, 1'b0, 1'b1, 4'(i), prog[i]);
        cycle("t1_run", 1'b1);
        check("t1_first", 32'(instruction), 32'h2312);
        cycle("t1_c1");
        check("t1_second", 32'(instruction), 32'h3312);
        cycle("t1_c2");
        check("t1_nop",     32'(instruction), 32'h6000);
        check("t1_done",    32'(done),        32'h1);
        check("t1_pc",      32'(pc),          32'h2);
        check("t1_retired", 32'(retired),     32'h2);
        cycle("t1_step_in_done", 1'b0, 1'b1);
        check("t1_step_ignored", 32'(instruction), 32'h6000);

        // Single steps with gaps on a program without HALT.
        hard_reset("t2_reset");
        for (int i = 0; i < 16; i++) prog[i] = rand_word();
        load_prog("t2_load");
        for (int k = 0; k < 3; k++) begin
            cycle("t2_step", 1'b0, 1'b1);
            check("t2_busy",  32'(busy),        32'h1);
            check("t2_instr", 32'(instruction), 32'(prog[k]));
            check("t2_pc",    32'(pc),          32'(k + 1));
            cycle("t2_gap");
            check("t2_busy_low", 32'(busy),        32'h0);
            check("t2_gap_nop",  32'(instruction), 32'h6000);
            cycle("t2_gap2");
        end

        // Halt at pc 5, resume, and run across the wrap.
        cycle("t3_run", 1'b1);
        cycle("t3_c");
        check("t3_pc_before_halt", 32'(pc), 32'h5);
        cycle("t3_halt", 1'b0, 1'b0, 1'b1);
        check("t3_halt_nop", 32'(instruction), 32'h6000);
        check("t3_halt_pc",  32'(pc),          32'h5);
        cycle("t3_idle");
        cycle("t3_resume", 1'b1);
        check("t3_resume_word", 32'(instruction), 32'(prog[5]));
        for (int i = 0; i < 12; i++) begin
            cycle("t3_wrap");
            check("t3_wrap_word", 32'(instruction), 32'(prog[4'(6 + i)]));
            check("t3_wrap_pc",   32'(pc),          32'((7 + i) % 16));
        end

        // A load while busy is dropped; run_start with step selects RUN.
        check("t4_ready_low", 32'(load_ready), 32'h0);
        cycle("t4_busy_load", 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, HLT);
        cycle("t4_c1");
        cycle("t4_c2");
        check("t4_dropped_word", 32'(instruction), 32'(prog[4]));
        check("t4_not_done",     32'(done),        32'h0);
        cycle("t4_halt", 1'b0, 1'b0, 1'b1);
        cycle("t4_both", 1'b1, 1'b1);
        cycle("t4_still_run");
        check("t4_run_wins", 32'(busy), 32'h1);
        cycle("t4_halt2", 1'b0, 1'b0, 1'b1);

        // Twenty-cycle run across the wrap, then saturation of the retire count.
        hard_reset("t5_reset");
        for (int i = 0; i < 16; i++) prog[i] = rand_word();
        load_prog("t5_load");
        cycle("t5_run", 1'b1);
        for (int k = 2; k <= 20; k++) begin
            cycle("t5_c");
            if (k == 17) check("t5_wrap_word", 32'(instruction), 32'(prog[0]));
        end
        check("t5_retired20", 32'(retired), 32'd20);
        check("t5_pc",        32'(pc),      32'd4);
        for (int k = 0; k < 250; k++) cycle("t5_sat");
        check("t5_saturate", 32'(retired), 32'd255);
        check("t6_busy_before_reset", 32'(busy), 32'h1);
        hard_reset("t6_midrun");

`ifdef PROG_SEQ_BKPT_EN
        for (int i = 0; i < 16; i++) prog[i] = rand_word();
        load_prog("t7_load");
        bkpt_en = 1'b1; bkpt_addr = 4'd3;
        cycle("t7_run", 1'b1);
        for (int i = 0; i < 8 && busy; i++) cycle("t7_wait");
        check("t7_paused",  32'(busy),        32'h0);
        check("t7_pc",      32'(pc),          32'h3);
        check("t7_nop",     32'(instruction), 32'h6000);
        cycle("t7_step", 1'b0, 1'b1);
        check("t7_step_word", 32'(instruction), 32'(prog[3]));
        check("t7_step_pc",   32'(pc),          32'h4);
        bkpt_en = 1'b0;
        cycle("t7_gap");
`endif

        // Randomized pulses and loads against the model.
        hard_reset("rand_reset");
        for (int i = 0; i < 16; i++) begin
            prog[i] = ($urandom_range(0, 7) == 0) ? HLT : rand_word();
        end
        load_prog("rand_load");
        for (int i = 0; i < 400; i++) begin
            logic [15:0] d;
            int          r;
            r = int'($urandom_range(0, 15));
            d = (r == 0) ? HLT : (r == 1) ? NOP : rand_word();
`ifdef PROG_SEQ_BKPT_EN
            bkpt_en   = ($urandom_range(0, 3) == 0);
            bkpt_addr = 4'($urandom);
`endif
            cycle("rand", $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, 4'($urandom), d);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
